carry_chain_join: RTL and testbench
===================================

# carry_chain_join

Downstream consumer of the 16-bit carry-select adder stage. Accepts a stream of per-chunk adder results `{p, g, s, t}`, least-significant chunk first. Resolves the inter-chunk carry serially, one chunk per accepted beat, and assembles a wide `N*W`-bit sum, carry-out and group propagate/generate. The wide result is presented on a valid/ready output.

## Interface
- `W`, 16: chunk width; must match the adder stage.
- `N`, 4: chunks per wide word (N ≥ 2).
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `in_valid`  in  1  chunk result valid.
- `in_ready`  out  1  block can accept a chunk.
- `in_res`  in  2W+2  chunk result, packed as follows:
  - `[2W+1]`: p.
  - `[2W]`: g.
  - `[2W-1:W]`: s, the sum with carry-in 1.
  - `[W-1:0]`: t, the sum with carry-in 0.
- `in_cin`  in  1  carry into chunk 0; sampled only when chunk 0 is accepted.
- `out_valid`  out  1  wide result valid.
- `out_ready`  in  1  consumer accepts result.
- `out_sum`  out  N*W  resolved sum; chunk k occupies `[k*W +: W]`.
- `out_cout`  out  1  carry out of chunk N-1.
- `out_gp`  out  1  group propagate (AND of all chunk p).
- `out_gg`  out  1  group generate over all chunks.

## Operation
- States:
  - `COLLECT`: `in_ready=1`, `out_valid=0`.
  - `HOLD`: `in_ready=0`, `out_valid=1`.
- A chunk is accepted when `in_valid && in_ready`.
- Chunk counter `cnt` runs 0..N-1. Carry register `c`.
- On acceptance of chunk k:
  - Effective carry-in `ci = (k==0) ? in_cin : c`.
  - `sum_k = ci ? s : t`; written into the sum register at slice k.
  - `c <= g | (p & ci)`.
  - Group terms: `gp <= (k==0 ? 1 : gp) & p`; `gg <= g | (p & (k==0 ? 0 : gg))`.
- Acceptance of chunk N-1:
  - `cnt` wraps to 0 and the state goes to `HOLD`.
  - `out_cout` equals the carry computed from chunk N-1.
- In `HOLD`, all outputs are stable until `out_valid && out_ready`. Then the state returns to `COLLECT`.
- No arithmetic beyond the 1-bit carry recurrence. No truncation: `out_sum` is exactly N*W bits.
- `in_valid` while `in_ready=0` is ignored; no chunk is lost, because the producer must hold its data.
- Reset at any time:
  - State is `COLLECT`, `cnt=0`, `c=0`.
  - `out_sum=0`, `out_cout=0`, `out_gp=0`, `out_gg=0`, `out_valid=0`.
  - A partial word is discarded.

## Timing
- All outputs are registered. `in_ready` is a pure decode of state.
- `out_valid` rises the cycle after chunk N-1 is accepted.
- Minimum latency: N accept cycles plus 1 cycle to `out_valid`.
- An output handshake in cycle T makes `in_ready=1` in cycle T+1.
- No chunk is accepted in the handshake cycle itself.
- Peak throughput: one word per N+1 cycles.
- A reset asserted in the same cycle as a chunk acceptance wins; the chunk is dropped.

## Structure
- Shared package `adder_pkg` holds the following:
  - `W`.
  - Field offsets `RES_P`, `RES_G`, `RES_S_HI/LO`, `RES_T_HI/LO`.
  - Result width `RES_W = 2*W+2`.
  - State enum `{COLLECT, HOLD}`.
- One combinational sub-module, `carry_select_cell`:
  - Inputs: `p, g, s, t, ci`.
  - Outputs: `sum, co`.
  - The group-term update lives in it too.
- The top module holds the counter, the FSM and the output registers.

## Test plan
(N=4, W=16.)
- Four chunks `p=1, g=0, s=0x0000, t=0xFFFF` with `in_cin=1` -> `out_sum=0`, `out_cout=1`, `out_gp=1`, `out_gg=0`.
- Same four chunks with `in_cin=0` -> `out_sum=0xFFFF_FFFF_FFFF_FFFF`, `out_cout=0`, `out_gp=1`, `out_gg=0`.
- Ripple case:
  - Chunk 0 is `p=0, g=1, t=0x0000, s=0x0001`.
  - Chunks 1–3 are `p=1, g=0, t=0xFFFF, s=0x0000`.
  - `in_cin=0`.
  - Expected: `out_sum=0x0000_0000_0000_0000`, `out_cout=1`, `out_gg=1`, `out_gp=0`.
- Backpressure:
  - Hold `out_ready=0` for 5 cycles after `out_valid`, with `in_valid=1` throughout.
  - Expected: `in_ready=0` and outputs bit-stable for all 5 cycles.
  - Expected: the first new chunk is accepted exactly 1 cycle after the handshake.
- Reset mid-word:
  - Assert `rst` for 1 cycle after 2 chunks are accepted.
  - Then send 4 fresh all-zero chunks (`t=s-1`, `p=g=0`) with `in_cin=0`.
  - Expected: `out_sum=0` with no stale data; `out_valid` is never asserted before the 4th fresh chunk.
- Streaming with `out_ready=1` and `in_valid=1` tied:
  - Run 3 back-to-back words.
  - Expected: `out_valid` pulses every 5 cycles, and each word matches a reference model.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared definitions for the carry-select adder stage and its consumers.
// Holds the chunk-result layout, the FSM state type and the group-term bundle.
package adder_pkg;

    localparam int W        = 16;
    localparam int RES_W    = 2*W + 2;
    localparam int RES_P    = 2*W + 1;
    localparam int RES_G    = 2*W;
    localparam int RES_S_HI = 2*W - 1;
    localparam int RES_S_LO = W;
    localparam int RES_T_HI = W - 1;
    localparam int RES_T_LO = 0;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    typedef struct packed {
        logic gp;
        logic gg;
    } grp_t;

endpackage

// File: rtl/carry_select_cell.sv
// One step of the serial carry resolution: picks the chunk sum for the
// incoming carry and folds the chunk p/g into the running group terms.
module carry_select_cell
    import adder_pkg::*;
#(
    parameter int W = adder_pkg::W
) (
    input  logic         p,
    input  logic         g,
    input  logic [W-1:0] s,
    input  logic [W-1:0] t,
    input  logic         ci,
    input  logic         first,
    input  grp_t         grp_in,
    output logic [W-1:0] sum,
    output logic         co,
    output grp_t         grp_out
);

    // Select, carry recurrence and group fold; first chunk restarts the fold.
    always_comb begin
        sum        = ci ? s : t;
        co         = g | (p & ci);
        grp_out.gp = (first ? 1'b1 : grp_in.gp) & p;
        grp_out.gg = g | (p & (first ? 1'b0 : grp_in.gg));
    end

endmodule

// File: rtl/carry_chain_join.sv
// Joins a least-significant-first stream of chunk adder results into one
// wide sum with carry-out and group p/g, presented on a valid/ready port.
module carry_chain_join
    import adder_pkg::*;
#(
    parameter int W = adder_pkg::W,
    parameter int N = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2*W+1:0]   in_res,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N*W-1:0]   out_sum,
    output logic             out_cout,
    output logic             out_gp,
    output logic             out_gg
);

    localparam int CW  = (N > 1) ? $clog2(N) : 1;
    localparam int P_B = 2*W + 1;
    localparam int G_B = 2*W;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            c_q, c_d;
    logic [N*W-1:0]  sum_q, sum_d;
    logic            cout_q, cout_d;
    grp_t            grp_q, grp_d;

    logic            accept;
    logic            first;
    logic            last;
    logic            ci;
    logic [W-1:0]    cell_sum;
    logic            cell_co;
    grp_t            cell_grp;

    assign accept = in_valid && in_ready;
    assign first  = (cnt_q == '0);
    assign last   = (cnt_q == CW'(N - 1));
    assign ci     = first ? in_cin : c_q;

    carry_select_cell #(
        .W (W)
    ) u_cell (
        .p       (in_res[P_B]),
        .g       (in_res[G_B]),
        .s       (in_res[2*W-1:W]),
        .t       (in_res[W-1:0]),
        .ci      (ci),
        .first   (first),
        .grp_in  (grp_q),
        .sum     (cell_sum),
        .co      (cell_co),
        .grp_out (cell_grp)
    );

    // State register plus datapath registers; reset discards any partial word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= COLLECT;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            grp_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            grp_q   <= grp_d;
        end
    end

    // Next state: finish a word on the last chunk, release it on handshake.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            COLLECT: if (accept && last) state_d = HOLD;
            HOLD:    if (out_ready)      state_d = COLLECT;
            default: state_d = COLLECT;
        endcase
    end

    // Handshake outputs are a pure decode of the state.
    always_comb begin
        in_ready  = (state_q == COLLECT);
        out_valid = (state_q == HOLD);
    end

    // Datapath: write the resolved chunk into its slice and advance the carry.
    always_comb begin
        cnt_d  = cnt_q;
        c_d    = c_q;
        sum_d  = sum_q;
        cout_d = cout_q;
        grp_d  = grp_q;
        if (accept) begin
            sum_d[int'(cnt_q)*W +: W] = cell_sum;
            c_d   = cell_co;
            grp_d = cell_grp;
            cnt_d = last ? '0 : cnt_q + CW'(1);
            if (last) cout_d = cell_co;
        end
    end

    assign out_sum  = sum_q;
    assign out_cout = cout_q;
    assign out_gp   = grp_q.gp;
    assign out_gg   = grp_q.gg;

endmodule

// File: tb/tb_carry_chain_join.sv
// Scoreboard bench for carry_chain_join: directed chunk streams with
// hand-computed or operand-derived expected wide results.
module tb_carry_chain_join;
    import adder_pkg::*;

    localparam int N  = 4;
    localparam int WW = N*W;

    typedef struct packed {
        logic [WW-1:0] sum;
        logic          cout;
        logic          gp;
        logic          gg;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [RES_W-1:0] in_res;
    logic             in_cin;
    logic             out_valid;
    logic             out_ready;
    logic [WW-1:0]    out_sum;
    logic             out_cout;
    logic             out_gp;
    logic             out_gg;

    exp_t exp_q[$];
    int   hs_q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    carry_chain_join #(.W(W), .N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_res    (in_res),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_gp    (out_gp),
        .out_gg    (out_gg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    function automatic logic [RES_W-1:0] mk(input logic p, input logic g,
                                            input logic [W-1:0] s,
                                            input logic [W-1:0] t);
        return {p, g, s, t};
    endfunction

    function automatic exp_t mkexp(input logic [WW-1:0] s, input logic co,
                                   input logic gp, input logic gg);
        exp_t e;
        e.sum = s; e.cout = co; e.gp = gp; e.gg = gg;
        return e;
    endfunction

    // Chunk results as the upstream adder would produce them for A+B.
    function automatic logic [N*RES_W-1:0] from_ops(input logic [WW-1:0] a,
                                                    input logic [WW-1:0] b);
        logic [N*RES_W-1:0] r;
        logic [W-1:0]       ak, bk;
        logic [W:0]         t0;
        r = '0;
        for (int k = 0; k < N; k++) begin
            ak = a[k*W +: W];
            bk = b[k*W +: W];
            t0 = {1'b0, ak} + {1'b0, bk};
            r[k*RES_W +: RES_W] = mk(&(ak ^ bk), t0[W], t0[W-1:0] + 1'b1,
                                     t0[W-1:0]);
        end
        return r;
    endfunction

    // Reference: plain wide addition of the original operands.
    function automatic exp_t ref_ops(input logic [WW-1:0] a,
                                     input logic [WW-1:0] b, input logic cin);
        logic [WW:0] f1, f0;
        f1 = {1'b0, a} + {1'b0, b} + {{WW{1'b0}}, cin};
        f0 = {1'b0, a} + {1'b0, b};
        return mkexp(f1[WW-1:0], f1[WW], &(a ^ b), f0[WW]);
    endfunction

    // Scoreboard monitor: compare whenever a result handshake is seen.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            hs_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_out: got sum %h, required none",
                         out_sum);
            end else begin
                e = exp_q.pop_front();
                chk("out_sum", out_sum, e.sum);
                chk("out_cout", 64'(out_cout), 64'(e.cout));
                chk("out_gp", 64'(out_gp), 64'(e.gp));
                chk("out_gg", 64'(out_gg), 64'(e.gg));
            end
        end
    end

    // Drive chunks [from, upto) of a word; starts and ends at posedge+1.
    task automatic send(input logic [N*RES_W-1:0] w, input logic cin,
                        input int from, input int upto);
        bit ok;
        int guard;
        for (int k = from; k < upto; k++) begin
            in_valid = 1'b1;
            in_res   = w[k*RES_W +: RES_W];
            in_cin   = cin;
            ok       = 1'b0;
            guard    = 0;
            while (!ok && guard < 64) begin
                @(negedge clk);
                ok = in_ready;
                @(posedge clk);
                #1;
                guard++;
            end
            if (!ok) begin
                n_vec++;
                n_bad++;
                $display("FAIL accept_timeout: chunk %0d not taken, required taken",
                         k);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 40) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (exp_q.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain_timeout: %0d results pending, required 0",
                     exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation stuck, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N*RES_W-1:0] w1, w3, wz;
        logic [WW-1:0]      a [3];
        logic [WW-1:0]      b [3];
        logic               ci [3];

        w1 = {N{mk(1'b1, 1'b0, 16'h0000, 16'hFFFF)}};
        w3 = {mk(1'b1, 1'b0, 16'h0000, 16'hFFFF),
              mk(1'b1, 1'b0, 16'h0000, 16'hFFFF),
              mk(1'b1, 1'b0, 16'h0000, 16'hFFFF),
              mk(1'b0, 1'b1, 16'h0001, 16'h0000)};
        wz = {N{mk(1'b0, 1'b0, 16'h0001, 16'h0000)}};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_res    = '0;
        in_cin    = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_sum", out_sum, 64'd0);
        chk("rst_out_cout", 64'(out_cout), 64'd0);
        chk("rst_out_gp", 64'(out_gp), 64'd0);
        chk("rst_out_gg", 64'(out_gg), 64'd0);
        @(posedge clk);
        #1;

        exp_q.push_back(mkexp(64'h0, 1'b1, 1'b1, 1'b0));
        send(w1, 1'b1, 0, N);
        exp_q.push_back(mkexp(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0));
        send(w1, 1'b0, 0, N);
        exp_q.push_back(mkexp(64'h0, 1'b1, 1'b0, 1'b1));
        send(w3, 1'b0, 0, N);
        drain();

        out_ready = 1'b0;
        exp_q.push_back(mkexp(64'h0, 1'b1, 1'b1, 1'b0));
        exp_q.push_back(mkexp(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0));
        send(w1, 1'b1, 0, N);
        in_valid = 1'b1;
        in_res   = w1[0 +: RES_W];
        in_cin   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_out_sum", out_sum, 64'd0);
            chk("bp_out_cout", 64'(out_cout), 64'd1);
            chk("bp_out_gp", 64'(out_gp), 64'd1);
            chk("bp_out_gg", 64'(out_gg), 64'd0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("hs_cycle_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("post_hs_in_ready", 64'(in_ready), 64'd1);
        chk("post_hs_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        send(w1, 1'b0, 1, N);
        drain();

        send(w1, 1'b1, 0, 2);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_res   = w1[2*RES_W +: RES_W];
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_out_sum", out_sum, 64'd0);
        chk("mid_rst_out_gp", 64'(out_gp), 64'd0);
        chk("mid_rst_out_gg", 64'(out_gg), 64'd0);
        @(posedge clk);
        #1;
        exp_q.push_back(mkexp(64'h0, 1'b0, 1'b0, 1'b0));
        send(wz, 1'b0, 0, N);
        drain();

        a[0] = 64'h0123_4567_89AB_CDEF; b[0] = 64'hFEDC_BA98_7654_3210;
        ci[0] = 1'b1;
        a[1] = 64'hFFFF_0000_FFFF_8000; b[1] = 64'h0001_0000_0000_8000;
        ci[1] = 1'b0;
        a[2] = 64'h7FFF_FFFF_FFFF_FFFF; b[2] = 64'h0000_0000_0000_0001;
        ci[2] = 1'b0;
        hs_q.delete();
        for (int i = 0; i < 3; i++) exp_q.push_back(ref_ops(a[i], b[i], ci[i]));
        for (int i = 0; i < 3; i++) send(from_ops(a[i], b[i]), ci[i], 0, N);
        drain();
        chk("stream_words", 64'(hs_q.size()), 64'd3);
        if (hs_q.size() == 3) begin
            chk("stream_gap_1", 64'(hs_q[1] - hs_q[0]), 64'd5);
            chk("stream_gap_2", 64'(hs_q[2] - hs_q[1]), 64'd5);
        end

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
